sc_cell_test_seq: RTL and testbench

//  Sequencer for on-die functional test of library cells (inv/nand2/nor2/mux2...) placed as test slots.

---
 rtl/sc_test_pkg.sv | 23 ++
 rtl/sc_slot_next_pri.sv | 32 +++
 rtl/sc_cell_test_seq.sv | 181 ++++++++++++++++++
 tb/tb_sc_cell_test_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_test_pkg.sv
// Shared types and constants for the library-cell test sequencer.
// Optional MISR signature support is compiled in with SC_TEST_MISR_EN.
package sc_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FIN
    } state_e;

    localparam int          VEC_W     = 3;
    localparam int          TT_W      = 8;
    localparam logic [7:0]  ERR_MAX   = 8'd255;
    localparam logic [15:0] MISR_POLY = 16'h1021;  // x^16+x^12+x^5+1
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/sc_slot_next_pri.sv
// Finds the lowest set mask bit at/above (above_i=0) or strictly above (above_i=1) base_i.
module sc_slot_next_pri #(
    parameter int NSLOT = 8,
    parameter int IDX_W = 3
) (
    input  logic [NSLOT-1:0] mask_i,
    input  logic [IDX_W-1:0] base_i,
    input  logic             above_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [NSLOT-1:0] elig;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_elig
        assign elig[gi] = mask_i[gi] &&
                          ((gi > int'(base_i)) || (!above_i && (gi == int'(base_i))));
    end

    // Scan downwards so the last hit is the lowest eligible slot.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sc_cell_test_seq.sv
// On-die library-cell test sequencer: walks masked slots through all 8 {S,B,A} vectors.
// Define SC_TEST_MISR_EN to add the 16-bit MISR signature output sig_o.
module sc_cell_test_seq
    import sc_test_pkg::*;
#(
    parameter int NSLOT      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [NSLOT-1:0]         slot_mask_i,
    input  logic [NSLOT*TT_W-1:0]    tt_i,
    input  logic                     y_in_i,
    output logic [VEC_W-1:0]         stim_o,
    output logic [$clog2(NSLOT)-1:0] sel_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [NSLOT-1:0]         fail_mask_o,
    output logic [7:0]               err_cnt_o
`ifdef SC_TEST_MISR_EN
    ,
    output logic [15:0]              sig_o
`endif
);

    localparam int SEL_W = $clog2(NSLOT);
    localparam int CNT_W = $clog2(SETTLE_CYC) + 1;

    state_e             state_q, state_d;
    logic [NSLOT-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   stim_q, stim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NSLOT-1:0]   fail_q, fail_d;
    logic [7:0]         err_q, err_d;
    logic               pass_q, pass_d;
`ifdef SC_TEST_MISR_EN
    logic [15:0]        sig_q, sig_d;
`endif

    logic               in_idle;
    logic               pri_found;
    logic [SEL_W-1:0]   pri_idx;
    logic               exp_y;

    // In IDLE the finder looks at the live mask from slot 0; while running it looks past SEL.
    assign in_idle = (state_q == IDLE);

    sc_slot_next_pri #(
        .NSLOT (NSLOT),
        .IDX_W (SEL_W)
    ) u_pri (
        .mask_i  (in_idle ? slot_mask_i : mask_q),
        .base_i  (in_idle ? '0 : sel_q),
        .above_i (!in_idle),
        .found_o (pri_found),
        .idx_o   (pri_idx)
    );

    assign exp_y = tt_i[{sel_q, vec_q}];

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef SC_TEST_MISR_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    fail_d = '0;
                    err_d  = '0;
`ifdef SC_TEST_MISR_EN
                    sig_d  = MISR_SEED;
`endif
                    if (pri_found) begin
                        mask_d  = slot_mask_i;
                        sel_d   = pri_idx;
                        vec_d   = '0;
                        state_d = APPLY;
                    end else begin
                        pass_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            APPLY: begin
                stim_d  = vec_q;
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (y_in_i != exp_y) begin
                    fail_d[sel_q] = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 8'd1;
                    end
                end
`ifdef SC_TEST_MISR_EN
                sig_d = misr_step(sig_q, 16'({5'(sel_q), vec_q, y_in_i}));
`endif
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    state_d = APPLY;
                end else if (pri_found) begin
                    sel_d   = pri_idx;
                    vec_d   = '0;
                    state_d = APPLY;
                end else begin
                    pass_d  = (fail_d == '0);
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            vec_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b1;
`ifdef SC_TEST_MISR_EN
            sig_q   <= MISR_SEED;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef SC_TEST_MISR_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign stim_o      = stim_q;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);
    assign pass_o      = pass_q;
    assign fail_mask_o = fail_q;
    assign err_cnt_o   = err_q;
`ifdef SC_TEST_MISR_EN
    assign sig_o       = sig_q;
`endif

endmodule

// File: tb/tb_sc_cell_test_seq.sv
// Directed bench: a 4-slot instance with cell models for most cases, a 32-slot one for saturation.
module tb_sc_cell_test_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4-slot instance: slot0 inv, slot1 nor2, slot2 nand2, slot3 mux2
    logic         start4;
    logic [3:0]   mask4;
    logic [31:0]  tt4;
    logic         y4;
    logic [2:0]   stim4;
    logic [1:0]   sel4;
    logic         busy4, done4, pass4;
    logic [3:0]   fail4;
    logic [7:0]   err4;

    // 32-slot instance: Y always the complement of the expected value
    logic         start32;
    logic [31:0]  mask32;
    logic [255:0] tt32;
    logic         y32;
    logic [2:0]   stim32;
    logic [4:0]   sel32;
    logic         busy32, done32, pass32;
    logic [31:0]  fail32;
    logic [7:0]   err32;

    int fault_slot;

    sc_cell_test_seq #(.NSLOT(4), .SETTLE_CYC(2)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .slot_mask_i(mask4), .tt_i(tt4),
        .y_in_i(y4), .stim_o(stim4), .sel_o(sel4), .busy_o(busy4), .done_o(done4),
        .pass_o(pass4), .fail_mask_o(fail4), .err_cnt_o(err4)
    );

    sc_cell_test_seq #(.NSLOT(32), .SETTLE_CYC(2)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start32), .slot_mask_i(mask32), .tt_i(tt32),
        .y_in_i(y32), .stim_o(stim32), .sel_o(sel32), .busy_o(busy32), .done_o(done32),
        .pass_o(pass32), .fail_mask_o(fail32), .err_cnt_o(err32)
    );

    // Behavioural cell models; a faulty slot is stuck-at-0
    always_comb begin
        case (sel4)
            2'd0:    y4 = ~stim4[0];
            2'd1:    y4 = ~(stim4[0] | stim4[1]);
            2'd2:    y4 = ~(stim4[0] & stim4[1]);
            default: y4 = stim4[2] ? stim4[1] : stim4[0];
        endcase
        if (int'(sel4) == fault_slot) y4 = 1'b0;
    end

    assign y32 = ~tt32[{sel32, stim32}];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Returns the cycle (START cycle = 1) in which DONE was seen
    task automatic run4(input logic [3:0] m, output int cyc);
        mask4  = m;
        start4 = 1'b1;
        cyc    = 1;
        do begin
            @(posedge clk); #1;
            start4 = 1'b0;
            cyc++;
        end while (!done4 && cyc < 4000);
    endtask

    task automatic run32(input logic [31:0] m, output int cyc);
        mask32  = m;
        start32 = 1'b1;
        cyc     = 1;
        do begin
            @(posedge clk); #1;
            start32 = 1'b0;
            cyc++;
        end while (!done32 && cyc < 4000);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         fault;
        logic [3:0] exp_fail;
        int         exp_err;
        logic       exp_pass;
        int         exp_cyc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cyc;
        int n;
        int saw_done;
        logic [2:0] prev_stim;
        logic [1:0] held_sel;
        logic [2:0] held_stim;
        logic [4:0] log_q[$];

        tbl[0] = '{4'b1111, -1, 4'b0000, 0, 1'b1, 130};
        tbl[1] = '{4'b1111,  2, 4'b0100, 6, 1'b0, 130};
        tbl[2] = '{4'b1010,  2, 4'b0000, 0, 1'b1,  66};
        tbl[3] = '{4'b0100,  2, 4'b0100, 6, 1'b0,  34};
        tbl[4] = '{4'b0001,  0, 4'b0001, 4, 1'b0,  34};
        tbl[5] = '{4'b1000,  3, 4'b1000, 4, 1'b0,  34};
        tbl[6] = '{4'b0000,  3, 4'b0000, 0, 1'b1,   2};

        tt4        = {8'hCA, 8'h77, 8'h11, 8'h55};
        tt32       = {32{8'hA5}};
        fault_slot = -1;
        start4 = 1'b0; mask4 = '0;
        start32 = 1'b0; mask32 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("reset stim", int'(stim4), 0);
        check("reset sel", int'(sel4), 0);
        check("reset busy", int'(busy4), 0);
        check("reset done", int'(done4), 0);
        check("reset pass", int'(pass4), 1);
        check("reset fail_mask", int'(fail4), 0);
        check("reset err_cnt", int'(err4), 0);

        for (int i = 0; i < 7; i++) begin
            fault_slot = tbl[i].fault;
            run4(tbl[i].mask, cyc);
            $display("run %0d: mask=%b fault=%0d done_cycle=%0d fail=%b err=%0d pass=%0d",
                     i, tbl[i].mask, tbl[i].fault, cyc, fail4, err4, pass4);
            check("done cycle", cyc, tbl[i].exp_cyc);
            check("fail_mask", int'(fail4), int'(tbl[i].exp_fail));
            check("err_cnt", int'(err4), tbl[i].exp_err);
            check("pass", int'(pass4), int'(tbl[i].exp_pass));
            check("busy in done cycle", int'(busy4), 1);
            @(posedge clk); #1;
            check("busy after done", int'(busy4), 0);
            check("done one cycle", int'(done4), 0);
        end

        // Slots 1 and 3 only: STIM walks 0..7 on each, SEL never touches 0 or 2
        fault_slot = -1;
        log_q.delete();
        prev_stim = stim4;
        mask4  = 4'b1010;
        start4 = 1'b1;
        cyc    = 1;
        do begin
            @(posedge clk); #1;
            start4 = 1'b0;
            cyc++;
            if (stim4 != prev_stim) log_q.push_back({sel4, stim4});
            prev_stim = stim4;
        end while (!done4 && cyc < 4000);
        $display("walk: mask=1010 done_cycle=%0d steps=%0d", cyc, log_q.size());
        check("walk done cycle", cyc, 66);
        check("walk steps", log_q.size(), 16);
        n = (log_q.size() < 16) ? log_q.size() : 16;
        for (int k = 0; k < n; k++) begin
            check("walk sel/stim", int'(log_q[k]), ((k < 8) ? 1 : 3) * 8 + (k % 8));
        end
        @(posedge clk); #1;

        // Empty mask: DONE the cycle after START, STIM/SEL untouched
        held_sel  = sel4;
        held_stim = stim4;
        run4(4'b0000, cyc);
        $display("empty: done_cycle=%0d sel=%0d stim=%0d", cyc, sel4, stim4);
        check("empty done cycle", cyc, 2);
        check("empty sel held", int'(sel4), int'(held_sel));
        check("empty stim held", int'(stim4), int'(held_stim));
        check("empty pass", int'(pass4), 1);
        @(posedge clk); #1;

        // Mid-run START ignored, then reset at cycle 20 aborts with no DONE
        fault_slot = 0;
        saw_done   = 0;
        mask4  = 4'b1111;
        start4 = 1'b1;
        cyc    = 1;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            start4 = (cyc == 10);
            if (cyc == 10) mask4 = 4'b0000;
            if (done4) saw_done = 1;
        end
        start4 = 1'b0;
        check("mid-run start ignored (no done)", saw_done, 0);
        check("busy before reset", int'(busy4), 1);
        check("errors seen before reset", int'(err4 != 0), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("abort: stim=%0d sel=%0d busy=%0d done=%0d pass=%0d fail=%b err=%0d",
                 stim4, sel4, busy4, done4, pass4, fail4, err4);
        check("abort stim", int'(stim4), 0);
        check("abort sel", int'(sel4), 0);
        check("abort busy", int'(busy4), 0);
        check("abort done", int'(done4), 0);
        check("abort pass", int'(pass4), 1);
        check("abort fail_mask", int'(fail4), 0);
        check("abort err_cnt", int'(err4), 0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done4 || busy4) saw_done = 1;
        end
        check("no done after abort", saw_done, 0);

        // Always-wrong slots: 64 errors per 8-slot run, cleared by START; 256 errors saturate
        for (int r = 0; r < 2; r++) begin
            run32(32'h0000_00FF, cyc);
            $display("all-fail run %0d: done_cycle=%0d fail=%h err=%0d pass=%0d",
                     r, cyc, fail32, err32, pass32);
            check("8-slot done cycle", cyc, 258);
            check("8-slot err_cnt", int'(err32), 64);
            check("8-slot fail_mask", int'(fail32), 32'h0000_00FF);
            check("8-slot pass", int'(pass32), 0);
            @(posedge clk); #1;
        end
        run32(32'hFFFF_FFFF, cyc);
        $display("saturate run: done_cycle=%0d fail=%h err=%0d pass=%0d", cyc, fail32, err32, pass32);
        check("32-slot done cycle", cyc, 1026);
        check("saturated err_cnt", int'(err32), 255);
        check("32-slot fail_mask", int'(fail32), 32'hFFFF_FFFF);
        check("32-slot pass", int'(pass32), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
